// File: rtl/six_digit_display_scanner_if.sv
// Display-side bundle between the lock controller and the 7-segment scanner.
// The controller side drives digit codes and status; the scanner returns the multiplexed bus.
interface six_digit_display_scanner_if;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] d4;
    logic [3:0] d5;
    logic [3:0] d6;
    logic       res;
    logic       alarm;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    modport master (
        output d1, d2, d3, d4, d5, d6, res, alarm,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  d1, d2, d3, d4, d5, d6, res, alarm,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/six_digit_display_scanner.sv
// Time-multiplexes six snapshotted digit codes onto one active-low 7-segment bus.
// Optional alarm blinking of the anodes is enabled with `define DISP_BLINK_EN.
module six_digit_display_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input logic                          clk,
    input logic                          clr_n,
    six_digit_display_scanner_if.slave   bus
);

    localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [2:0]  IDX_LAST = 3'd5;

    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [3:0]  shadow [6];
    logic        res_s;
    logic        alarm_s;
    logic        frame_start;
    logic        guard;
    logic        an_force_off;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hE:    s = 7'h06;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign frame_start = (cnt == 16'd0) && (idx == 3'd0);
    assign guard       = (cnt == 16'd0);

    // Slot timing: cnt is the dwell counter, idx selects the digit slot.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= 16'd0;
            idx <= 3'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= 16'd0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Whole-frame snapshot so controller writes mid-frame never tear the display.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 6; i++) shadow[i] <= 4'hF;
            res_s   <= 1'b0;
            alarm_s <= 1'b0;
        end else if (frame_start) begin
            shadow[0] <= bus.d1;
            shadow[1] <= bus.d2;
            shadow[2] <= bus.d3;
            shadow[3] <= bus.d4;
            shadow[4] <= bus.d5;
            shadow[5] <= bus.d6;
            res_s     <= bus.res;
            alarm_s   <= bus.alarm;
        end
    end

`ifdef DISP_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] blink_cnt;
    logic       blink_ph;

    // Uses alarm_s from before the snapshot, so blinking starts one frame after alarm is seen.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            blink_cnt <= 8'd0;
            blink_ph  <= 1'b0;
        end else if (frame_start) begin
            if (!alarm_s) begin
                blink_cnt <= 8'd0;
                blink_ph  <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= 8'd0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    assign an_force_off = alarm_s && blink_ph;
`else
    logic alarm_unused;
    assign alarm_unused = alarm_s;
    assign an_force_off = 1'b0;
`endif

    // Output decode depends only on registered state, never on the live inputs.
    always_comb begin
        bus.an  = 6'b111111;
        bus.seg = 7'h7F;
        bus.dp  = 1'b1;
        if (!guard) begin
            bus.an  = ~(6'b000001 << idx);
            bus.seg = seg_decode(shadow[idx]);
            bus.dp  = ~(res_s && (idx == IDX_LAST));
            if (an_force_off) bus.an = 6'b111111;
        end
    end

    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_six_digit_display_scanner.sv
// Directed bench for six_digit_display_scanner with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_six_digit_display_scanner;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    int   total  = 0;
    int   passed = 0;

    six_digit_display_scanner_if bus ();

    six_digit_display_scanner #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // an per idx, idx 0 in the low six bits
    logic [35:0] an_tab = {6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
        bus.d1 = a; bus.d2 = b; bus.d3 = c; bus.d4 = d; bus.d5 = e; bus.d6 = f;
    endtask

    // Walks one frame from the (cnt=0, idx=0) state; segs holds the expected pattern per idx.
    task automatic run_frame(input string name, input logic [41:0] segs, input logic dp5,
                             input logic blank, input int chg_at, input logic [3:0] chg_val);
        for (int i = 0; i < 24; i++) begin
            int k;
            int c;
            k = i / 4;
            c = i % 4;
            if (c == 0) begin
                chk($sformatf("%s i%0d guard an", name, i), 32'(bus.an), 32'h3F);
                chk($sformatf("%s i%0d guard seg", name, i), 32'(bus.seg), 32'h7F);
                chk($sformatf("%s i%0d guard dp", name, i), 32'(bus.dp), 32'h1);
                chk($sformatf("%s i%0d fs", name, i), 32'(bus.frame_start), (k == 0) ? 32'h1 : 32'h0);
            end else begin
                chk($sformatf("%s i%0d an", name, i), 32'(bus.an),
                    blank ? 32'h3F : 32'(an_tab[6*k +: 6]));
                chk($sformatf("%s i%0d seg", name, i), 32'(bus.seg), 32'(segs[7*k +: 7]));
                chk($sformatf("%s i%0d dp", name, i), 32'(bus.dp),
                    (dp5 && k == 5) ? 32'h0 : 32'h1);
                chk($sformatf("%s i%0d fs", name, i), 32'(bus.frame_start), 32'h0);
            end
            if (i == chg_at) bus.d3 = chg_val;
            tick();
        end
    endtask

    localparam logic [41:0] SEG_123456 = {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    localparam logic [41:0] SEG_129456 = {7'h02, 7'h12, 7'h19, 7'h10, 7'h24, 7'h79};
    localparam logic [41:0] SEG_EC9456 = {7'h02, 7'h12, 7'h19, 7'h10, 7'h7F, 7'h06};

    initial begin
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        bus.res = 1'b0;
`ifdef DISP_BLINK_EN
        bus.alarm = 1'b0;
`else
        bus.alarm = 1'b1;
`endif
        tick();
        tick();
        chk("rst an", 32'(bus.an), 32'h3F);
        chk("rst seg", 32'(bus.seg), 32'h7F);
        chk("rst dp", 32'(bus.dp), 32'h1);
        chk("rst fs", 32'(bus.frame_start), 32'h1);

        clr_n = 1'b1;
        run_frame("f0", SEG_123456, 1'b0, 1'b0, 6, 4'd9);
        run_frame("f1", SEG_129456, 1'b0, 1'b0, -1, 4'd0);

        // Written right before the snapshot edge: taken for the whole of the next frame.
        bus.d1 = 4'hE;
        bus.d2 = 4'hC;
        bus.res = 1'b1;
        run_frame("f2", SEG_EC9456, 1'b1, 1'b0, -1, 4'd0);

        for (int i = 0; i < 10; i++) tick();
        chk("mid an", 32'(bus.an), 32'h3B);
        chk("mid seg", 32'(bus.seg), 32'h10);
        clr_n = 1'b0;
        #1;
        chk("arst an", 32'(bus.an), 32'h3F);
        chk("arst seg", 32'(bus.seg), 32'h7F);
        chk("arst dp", 32'(bus.dp), 32'h1);
        chk("arst fs", 32'(bus.frame_start), 32'h1);
        tick();
        chk("arst hold an", 32'(bus.an), 32'h3F);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        bus.res = 1'b0;
        clr_n = 1'b1;
        run_frame("r0", SEG_123456, 1'b0, 1'b0, -1, 4'd0);

`ifdef DISP_BLINK_EN
        bus.alarm = 1'b1;
        run_frame("b0", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
        run_frame("b1", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
        run_frame("b2", SEG_123456, 1'b0, 1'b1, -1, 4'd0);
        run_frame("b3", SEG_123456, 1'b0, 1'b1, -1, 4'd0);
        run_frame("b4", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
        run_frame("b5", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
        run_frame("b6", SEG_123456, 1'b0, 1'b1, -1, 4'd0);
        bus.alarm = 1'b0;
        run_frame("b7", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
        run_frame("b8", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
`else
        run_frame("n0", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
        run_frame("n1", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
        run_frame("n2", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
        run_frame("n3", SEG_123456, 1'b0, 1'b0, -1, 4'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
